// File: rtl/bist_signature_analyzer.sv
// MISR response compactor for the BIST controller; compares the final signature with GOLDEN.
// Optional macro SA_CYCLE_CHECK_EN adds a saturating compacted-cycle counter to the verdict.
module bist_signature_analyzer #(
  parameter int               WIDTH      = 16,
  parameter logic [WIDTH-1:0] POLY       = 16'hD008,
  parameter logic [WIDTH-1:0] SEED       = 16'hFFFF,
  parameter logic [WIDTH-1:0] GOLDEN     = 16'h0000,
  parameter int               EXP_CYCLES = 100,
  parameter int               CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init,
  input  logic             running,
  input  logic             finish,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] signature,
  output logic             pass,
  output logic             fail,
`ifdef SA_CYCLE_CHECK_EN
  output logic [CNT_W-1:0] cycle_count,
`endif
  output logic             done
);

  // Strobe protocol: init, running and finish are single-cycle qualifiers sampled on
  // the rising edge with priority init > running/finish; there is no back-pressure.
  // done acts as the verdict-valid flag: pass/fail are meaningful only while done=1.
  typedef enum logic [1:0] {IDLE, COMPACT, CHECK, DONE} state_t;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] sig_q, sig_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sig_step;
  logic             verdict_ok;

  assign sig_step = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0) ^ data_in;

`ifdef SA_CYCLE_CHECK_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign verdict_ok  = (sig_q == GOLDEN) && (cnt_q == CNT_W'(EXP_CYCLES));
  assign cycle_count = cnt_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{EXP_CYCLES, CNT_W};
  assign verdict_ok = (sig_q == GOLDEN);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (init) begin
      next_state = COMPACT;
    end else begin
      unique case (state)
        IDLE:    next_state = IDLE;
        COMPACT: if (finish) next_state = CHECK;
        CHECK:   next_state = DONE;
        DONE:    next_state = DONE;
      endcase
    end
  end

  always_comb begin
    sig_d  = sig_q;
    pass_d = pass_q;
    fail_d = fail_q;
    done_d = done_q;
`ifdef SA_CYCLE_CHECK_EN
    cnt_d  = cnt_q;
`endif
    if (init) begin
      sig_d  = SEED;
      pass_d = 1'b0;
      fail_d = 1'b0;
      done_d = 1'b0;
`ifdef SA_CYCLE_CHECK_EN
      cnt_d  = '0;
`endif
    end else begin
      unique case (state)
        COMPACT: begin
          // A finish in the same cycle still compacts this cycle's word first.
          if (running) begin
            sig_d = sig_step;
`ifdef SA_CYCLE_CHECK_EN
            if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
`endif
          end
        end
        CHECK: begin
          pass_d = verdict_ok;
          fail_d = ~verdict_ok;
          done_d = 1'b1;
        end
        IDLE, DONE: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sig_q  <= '0;
      pass_q <= 1'b0;
      fail_q <= 1'b0;
      done_q <= 1'b0;
`ifdef SA_CYCLE_CHECK_EN
      cnt_q  <= '0;
`endif
    end else begin
      sig_q  <= sig_d;
      pass_q <= pass_d;
      fail_q <= fail_d;
      done_q <= done_d;
`ifdef SA_CYCLE_CHECK_EN
      cnt_q  <= cnt_d;
`endif
    end
  end

  assign signature = sig_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign done      = done_q;

endmodule

// File: tb/tb_bist_signature_analyzer.sv
// Randomized scoreboard bench for bist_signature_analyzer (WIDTH=4, POLY=3, SEED=1, GOLDEN=3).
module tb_bist_signature_analyzer;

  localparam int W          = 4;
  localparam int POLY_I     = 3;
  localparam int SEED_I     = 1;
  localparam int GOLDEN_I   = 3;
  localparam int EXP_CYC    = 4;
  localparam int CW         = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         init = 1'b0;
  logic         running = 1'b0;
  logic         finish = 1'b0;
  logic [W-1:0] data_in = '0;
  logic [W-1:0] signature;
  logic         pass, fail, done;
`ifdef SA_CYCLE_CHECK_EN
  logic [CW-1:0] cycle_count;
  int            cnt_exp_q[$];
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [W+1:0] exp_q[$];

  // Behavioural model: signature as an integer in GF(2) arithmetic, plus an armed flag.
  int m_sig   = 0;
  int m_cnt   = 0;
  bit m_armed = 0;

  bist_signature_analyzer #(
    .WIDTH(W), .POLY(4'h3), .SEED(4'h1), .GOLDEN(4'h3),
    .EXP_CYCLES(EXP_CYC), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .init(init), .running(running), .finish(finish),
    .data_in(data_in), .signature(signature), .pass(pass), .fail(fail),
`ifdef SA_CYCLE_CHECK_EN
    .cycle_count(cycle_count),
`endif
    .done(done)
  );

  always #5 clk = ~clk;

  function automatic int mul_x_add(int s, int d);
    int t;
    t = s * 2;
    if (t >= (1 << W)) t = (t - (1 << W)) ^ POLY_I;
    return t ^ d;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(bit i, bit r, bit f, int d);
    bit ok;
    @(negedge clk);
    init    = i;
    running = r;
    finish  = f;
    data_in = W'(d);
    if (i) begin
      m_sig = SEED_I; m_cnt = 0; m_armed = 1;
    end else if (m_armed) begin
      if (r) begin
        m_sig = mul_x_add(m_sig, d);
        if (m_cnt < (1 << CW) - 1) m_cnt++;
      end
      if (f) begin
        m_armed = 0;
        ok = (m_sig == GOLDEN_I);
`ifdef SA_CYCLE_CHECK_EN
        ok = ok && (m_cnt == EXP_CYC);
        cnt_exp_q.push_back(m_cnt);
`endif
        exp_q.push_back({W'(m_sig), ok, ~ok});
      end
    end
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) drive(0, 0, 0, 0);
  endtask

  task automatic check_sig(string name);
    @(posedge clk);
    #1;
    chk(name, int'(signature), m_sig);
  endtask

  task automatic zero_run(int n);
    drive(1, 0, 0, 0);
    for (int k = 0; k < n; k++) drive(0, 1, 0, 0);
    drive(0, 0, 1, 0);
    idle(2);
  endtask

  // Monitor: verdict compared whenever done rises; invariants every cycle.
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    logic [W+1:0] e;
    chk("inv_not_both", int'(pass && fail), 0);
    if (!done) chk("inv_idle_clear", int'({pass, fail}), 0);
    if (done && !done_prev) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_verdict", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("verdict_sig", int'(signature), int'(e[W+1:2]));
        chk("verdict_pass", int'(pass), int'(e[1]));
        chk("verdict_fail", int'(fail), int'(e[0]));
`ifdef SA_CYCLE_CHECK_EN
        chk("verdict_cnt", int'(cycle_count), cnt_exp_q.pop_front());
`endif
      end
    end
    done_prev <= done;
  end

  initial begin
    int len;
    bit r;
    // 1. async reset pulse at 3ns
    #3 reset = 1'b1;
    #1;
    chk("reset_sig", int'(signature), 0);
    chk("reset_flags", int'({pass, fail, done}), 0);
    #2 reset = 1'b0;

    // 2. four zero cycles -> 3, pass
    zero_run(4);
    chk("t2_sig", int'(signature), 3);
    // 3. five zero cycles -> 6, fail
    zero_run(5);
    chk("t3_sig", int'(signature), 6);

    // 4. one cycle of data 2 -> 0, then fail
    drive(1, 0, 0, 0);
    drive(0, 1, 0, 2);
    check_sig("t4_sig_before_finish");
    chk("t4_sig_zero", m_sig, 0);
    drive(0, 0, 1, 0);
    idle(2);

    // 5. restart mid-run
    drive(1, 0, 0, 0);
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 0);
    zero_run(4);
    chk("t5_sig", int'(signature), 3);

    // 6. async reset mid-run, later finish ignored
    drive(1, 0, 0, 0);
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 0);
    @(posedge clk);
    #2 reset = 1'b1;
    m_sig = 0; m_cnt = 0; m_armed = 0;
    #1;
    chk("t6_reset_sig", int'(signature), 0);
    chk("t6_reset_flags", int'({pass, fail, done}), 0);
    #1 reset = 1'b0;
    drive(0, 0, 1, 0);
    drive(0, 1, 0, 5);
    idle(2);
    chk("t6_done_low", int'(done), 0);
    chk("t6_sig_held", int'(signature), 0);

    // Randomized runs, including finish with running in the same cycle and
    // running strobes after the verdict that must be ignored.
    for (int t = 0; t < 30; t++) begin
      drive(1, 0, 0, 0);
      len = $urandom_range(0, 20);
      for (int k = 0; k < len; k++) begin
        r = ($urandom_range(0, 3) != 0);
        drive(0, r, 0, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 15)) : 0);
      end
      drive(0, $urandom_range(0, 1) == 1, 1, $urandom_range(0, 15));
      idle(2);
      drive(0, 1, $urandom_range(0, 1) == 1, $urandom_range(0, 15));
      check_sig("rand_sig_frozen");
    end

    idle(3);
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
